// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and data-bit limits.
// Build option UART_TX_BREAK_EN adds the BREAK state.
package uart_pkg;

  localparam logic [3:0] MIN_DATA_BITS   = 4'd5;
  localparam int         DEFAULT_DIVISOR = 437;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
`ifdef UART_TX_BREAK_EN
    ST_CLEANUP = 3'd5,
    ST_BREAK   = 3'd6
`else
    ST_CLEANUP = 3'd5
`endif
  } state_t;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < MIN_DATA_BITS) return MIN_DATA_BITS;
    if (req > max_bits)      return max_bits;
    return req;
  endfunction

  // Mode 3 is reserved and behaves like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Command-side handshake and frame-format bundle between the register block and
// the configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int MAX_DATA_BITS     = 9,
  parameter int CONFIG_DATA_WIDTH = 32
);

  logic                         i_Tx_DV;
  logic                         o_Tx_Ready;
  logic [MAX_DATA_BITS-1:0]     i_Tx_Byte;
  logic [CONFIG_DATA_WIDTH-1:0] config_data;
  logic [3:0]                   i_Data_Bits;
  logic [1:0]                   i_Parity_Mode;
  logic                         i_Stop_Bits;

  modport master (
    output i_Tx_DV, i_Tx_Byte, config_data, i_Data_Bits, i_Parity_Mode, i_Stop_Bits,
    input  o_Tx_Ready
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte, config_data, i_Data_Bits, i_Parity_Mode, i_Stop_Bits,
    output o_Tx_Ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Loadable bit-period counter: latches a divisor (clamped to >= 1) and strobes
// tick on the last clock of every bit while enabled.
module uart_baud_tick #(
  parameter int WIDTH         = 32,
  parameter int RESET_DIVISOR = 437
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] divisor,
  input  logic             enable,
  output logic             tick
);

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] cnt_q;

  // div_q is never zero, so div_q - 1 cannot wrap.
  assign tick = enable && (cnt_q == div_q - WIDTH'(1));

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      div_q <= WIDTH'(RESET_DIVISOR);
      cnt_q <= '0;
    end else begin
      if (load) begin
        div_q <= (divisor == '0) ? WIDTH'(1) : divisor;
      end
      if (load || !enable || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, 5..MAX_DATA_BITS data bits LSB first,
// optional parity, 1 or 2 stop bits. Build option UART_TX_BREAK_EN adds i_Break.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS     = 9,
  parameter int CONFIG_DATA_WIDTH = 32,
  parameter int RESET_DIVISOR     = DEFAULT_DIVISOR
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
`ifdef UART_TX_BREAK_EN
  input  logic          i_Break,
`endif
  uart_tx_cfg_if.slave  tx_if,
  output logic          o_Tx_Active,
  output logic          o_Tx_Serial,
  output logic          o_Tx_Done
);

  localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

  state_t                   state, state_next;
  logic [MAX_DATA_BITS-1:0] shift_q;
  logic [MAX_DATA_BITS-1:0] data_mask;
  logic [3:0]               nbits_q, n_req;
  logic [3:0]               bit_idx_q, bit_idx_next;
  logic                     par_en_q, par_bit_q, stop2_q;
  logic                     serial_next, active_next, done_next;
  logic                     shift_en, accept, tick, baud_en, break_req;

`ifdef UART_TX_BREAK_EN
  localparam int BRK_W = CONFIG_DATA_WIDTH + 4;
  logic [BRK_W-1:0]             brk_cnt_q, brk_min;
  logic [CONFIG_DATA_WIDTH-1:0] d_now;
  logic [3:0]                   frame_bits_now;

  assign break_req = i_Break;
  assign d_now     = (tx_if.config_data == '0) ? CONFIG_DATA_WIDTH'(1) : tx_if.config_data;
  assign frame_bits_now = 4'd1 + n_req + {3'd0, parity_enabled(tx_if.i_Parity_Mode)}
                        + (tx_if.i_Stop_Bits ? 4'd2 : 4'd1);
  assign brk_min = BRK_W'(frame_bits_now) * BRK_W'(d_now);

  // Saturating count of cycles spent in BREAK, measured from the entry edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || state != ST_BREAK) begin
      brk_cnt_q <= '0;
    end else if (brk_cnt_q != '1) begin
      brk_cnt_q <= brk_cnt_q + BRK_W'(1);
    end
  end
`else
  assign break_req = 1'b0;
`endif

  assign tx_if.o_Tx_Ready = (state == ST_IDLE) && !i_Reset;
  assign accept           = tx_if.i_Tx_DV && tx_if.o_Tx_Ready && !break_req;
  assign baud_en          = (state == ST_START) || (state == ST_DATA) ||
                            (state == ST_PARITY) || (state == ST_STOP);
  assign n_req            = clamp_data_bits(tx_if.i_Data_Bits, MAX_BITS);

  always_comb begin
    data_mask = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      data_mask[i] = (4'(i) < n_req);
    end
  end

  uart_baud_tick #(
    .WIDTH         (CONFIG_DATA_WIDTH),
    .RESET_DIVISOR (RESET_DIVISOR)
  ) u_baud (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .load    (accept),
    .divisor (tx_if.config_data),
    .enable  (baud_en),
    .tick    (tick)
  );

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    serial_next  = o_Tx_Serial;
    active_next  = o_Tx_Active;
    done_next    = 1'b0;
    bit_idx_next = bit_idx_q;
    shift_en     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        serial_next = 1'b1;
        active_next = 1'b0;
        if (break_req) begin
`ifdef UART_TX_BREAK_EN
          state_next  = ST_BREAK;
          serial_next = 1'b0;
          active_next = 1'b1;
`endif
        end else if (accept) begin
          state_next  = ST_START;
          serial_next = 1'b0;
          active_next = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_next   = ST_DATA;
          serial_next  = shift_q[0];
          shift_en     = 1'b1;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == nbits_q - 4'd1) begin
            bit_idx_next = '0;
            if (par_en_q) begin
              state_next  = ST_PARITY;
              serial_next = par_bit_q;
            end else begin
              state_next  = ST_STOP;
              serial_next = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx_q + 4'd1;
            serial_next  = shift_q[0];
            shift_en     = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_next   = ST_STOP;
          serial_next  = 1'b1;
          bit_idx_next = '0;
        end
      end
      ST_STOP: begin
        serial_next = 1'b1;
        // bit_idx_q counts completed stop bits when two are configured.
        if (tick) begin
          if (stop2_q && bit_idx_q == 4'd0) begin
            bit_idx_next = 4'd1;
          end else begin
            state_next   = ST_CLEANUP;
            active_next  = 1'b0;
            done_next    = 1'b1;
            bit_idx_next = '0;
          end
        end
      end
      ST_CLEANUP: begin
        state_next  = ST_IDLE;
        serial_next = 1'b1;
        active_next = 1'b0;
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        serial_next = 1'b0;
        active_next = 1'b1;
        if (!i_Break && brk_cnt_q >= brk_min - BRK_W'(1)) begin
          state_next  = ST_IDLE;
          serial_next = 1'b1;
          active_next = 1'b0;
        end
      end
`endif
      default: begin
        state_next  = ST_IDLE;
        serial_next = 1'b1;
        active_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      nbits_q     <= MIN_DATA_BITS;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
    end else begin
      state       <= state_next;
      o_Tx_Serial <= serial_next;
      o_Tx_Active <= active_next;
      o_Tx_Done   <= done_next;
      bit_idx_q   <= bit_idx_next;
      if (accept) begin
        shift_q   <= tx_if.i_Tx_Byte & data_mask;
        nbits_q   <= n_req;
        par_en_q  <= parity_enabled(tx_if.i_Parity_Mode);
        par_bit_q <= (^(tx_if.i_Tx_Byte & data_mask)) ^ (tx_if.i_Parity_Mode == PAR_ODD);
        stop2_q   <= tx_if.i_Stop_Bits;
      end else if (shift_en) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

endmodule
